// File: rtl/ch1_sweep.sv
// ch1_sweep: channel-1 frequency sweep unit (NR10/NR13/NR14 registers and the 128 Hz sweep sequencer).
// Optional feature macro CH1_SWEEP_NEG_QUIRK_EN: leaving negate mode after a negate calculation disables the channel.
module ch1_sweep (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_wr,
    input  logic        ff10,
    input  logic        ff13,
    input  logic        ff14,
    input  logic [7:0]  d,
    input  logic        sweep_tick,
    output logic [10:0] freq,
    output logic [7:0]  nr10_q,
    output logic        ch1_off,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    // Bit 11 of the result flags overflow; a subtraction can never go below zero.
    function automatic logic [11:0] sweep_calc(
        input logic [10:0] shadow,
        input logic [2:0]  shift,
        input logic        negate
    );
        logic [11:0] base;
        logic [11:0] delta;
        base  = {1'b0, shadow};
        delta = {1'b0, shadow >> shift};
        sweep_calc = negate ? (base - delta) : (base + delta);
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  period_r, period_s;
    logic        negate_r, negate_s;
    logic [2:0]  shift_r, shift_s;
    logic [10:0] freq_r, freq_s;
    logic [10:0] shadow_r, shadow_s;
    logic [10:0] new_r, new_s;
    logic [3:0]  timer_r, timer_s;
    logic        en_r, en_s;
    logic        off_r, off_s;
    logic        busy_r;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
    logic        neg_used_r, neg_used_s;
`endif

    logic        wr10_s, wr13_s, wr14_s, trigger_s;
    logic [11:0] calc_s;
    logic [3:0]  reload_s;

    assign wr10_s    = apu_wr & ff10;
    assign wr13_s    = apu_wr & ff13;
    assign wr14_s    = apu_wr & ff14;
    assign trigger_s = wr14_s & d[7];
    assign calc_s    = sweep_calc(shadow_r, shift_r, negate_r);
    assign reload_s  = (period_r == 3'd0) ? 4'd8 : {1'b0, period_r};

    // Next-state and datapath: CPU writes first, a trigger overrides the sequencer.
    always_comb begin
        state_s  = state_r;
        period_s = wr10_s ? d[6:4] : period_r;
        negate_s = wr10_s ? d[3]   : negate_r;
        shift_s  = wr10_s ? d[2:0] : shift_r;
        freq_s   = {(wr14_s ? d[2:0] : freq_r[10:8]), (wr13_s ? d : freq_r[7:0])};
        shadow_s = shadow_r;
        new_s    = new_r;
        timer_s  = timer_r;
        en_s     = en_r;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
        neg_used_s = neg_used_r;
        off_s      = off_r | (wr10_s & ~d[3] & neg_used_r);
`else
        off_s      = off_r;
`endif
        if (trigger_s) begin
            shadow_s = freq_s;
            timer_s  = reload_s;
            en_s     = (period_r != 3'd0) || (shift_r != 3'd0);
            off_s    = 1'b0;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
            neg_used_s = 1'b0;
`endif
            state_s  = (shift_r != 3'd0) ? S_CHECK : S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (sweep_tick) begin
                        if (timer_r <= 4'd1) begin
                            timer_s = reload_s;
                            state_s = (en_r && (period_r != 3'd0) && !off_r) ? S_CALC : S_IDLE;
                        end else begin
                            timer_s = timer_r - 4'd1;
                        end
                    end else begin
                        timer_s = timer_r;
                    end
                end
                S_CALC: begin
`ifdef CH1_SWEEP_NEG_QUIRK_EN
                    neg_used_s = neg_used_r | negate_r;
`endif
                    if (calc_s[11]) begin
                        off_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        new_s   = calc_s[10:0];
                        state_s = (shift_r != 3'd0) ? S_WRITE : S_IDLE;
                    end
                end
                S_WRITE: begin
                    // CPU data wins for the bits it writes this clock; shadow always takes the sweep result.
                    shadow_s = new_r;
                    freq_s   = {(wr14_s ? d[2:0] : new_r[10:8]), (wr13_s ? d : new_r[7:0])};
                    state_s  = S_CHECK;
                end
                S_CHECK: begin
                    off_s   = off_s | calc_s[11];
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            period_r <= 3'd0;
            negate_r <= 1'b0;
            shift_r  <= 3'd0;
            freq_r   <= 11'd0;
            shadow_r <= 11'd0;
            new_r    <= 11'd0;
            timer_r  <= 4'd0;
            en_r     <= 1'b0;
            off_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            period_r <= period_s;
            negate_r <= negate_s;
            shift_r  <= shift_s;
            freq_r   <= freq_s;
            shadow_r <= shadow_s;
            new_r    <= new_s;
            timer_r  <= timer_s;
            en_r     <= en_s;
            off_r    <= off_s;
            busy_r   <= (state_s != S_IDLE);
        end
    end

`ifdef CH1_SWEEP_NEG_QUIRK_EN
    // Remembers that a negate-mode calculation ran since the last trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_used_r <= 1'b0;
        end else begin
            neg_used_r <= neg_used_s;
        end
    end
`endif

    assign freq    = freq_r;
    assign nr10_q  = {1'b1, period_r, negate_r, shift_r};
    assign ch1_off = off_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_ch1_sweep.sv
// Self-checking bench for ch1_sweep: directed scenarios with literal expectations plus
// randomized register/tick traffic compared every clock against a behavioural model.
`timescale 1ns/1ps
module tb_ch1_sweep;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        apu_wr = 1'b0;
    logic        ff10 = 1'b0;
    logic        ff13 = 1'b0;
    logic        ff14 = 1'b0;
    logic [7:0]  d = 8'd0;
    logic        sweep_tick = 1'b0;
    logic [10:0] freq;
    logic [7:0]  nr10_q;
    logic        ch1_off;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    ch1_sweep dut (
        .clk(clk), .reset(reset), .apu_wr(apu_wr), .ff10(ff10), .ff13(ff13), .ff14(ff14),
        .d(d), .sweep_tick(sweep_tick), .freq(freq), .nr10_q(nr10_q), .ch1_off(ch1_off), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model state; m_step counts the clocks still needed by an in-flight update
    // (3: compute pending, 2: freq write pending, 1: overflow re-check pending, 0: none).
    int m_period = 0, m_negate = 0, m_shift = 0, m_freq = 0, m_shadow = 0;
    int m_timer = 0, m_en = 0, m_off = 0, m_neg_used = 0, m_step = 0, m_new = 0;

    function automatic int sweep_of(int s, int sh, int neg);
        return (neg != 0) ? s - (s >> sh) : s + (s >> sh);
    endfunction

    task automatic model_step();
        int n_period, n_negate, n_shift, n_freq, n_shadow, n_timer, n_en, n_off, n_neg_used, n_step, n_new;
        int v, lo, hi;
        bit w10, w13, w14;
        w10 = apu_wr && ff10;
        w13 = apu_wr && ff13;
        w14 = apu_wr && ff14;
        n_period = m_period; n_negate = m_negate; n_shift = m_shift; n_freq = m_freq;
        n_shadow = m_shadow; n_timer = m_timer; n_en = m_en; n_off = m_off;
        n_neg_used = m_neg_used; n_step = m_step; n_new = m_new;
        if (reset) begin
            n_period = 0; n_negate = 0; n_shift = 0; n_freq = 0; n_shadow = 0;
            n_timer = 0; n_en = 0; n_off = 0; n_neg_used = 0; n_step = 0; n_new = 0;
        end else begin
            if (w10) begin
                n_period = int'(d[6:4]); n_negate = int'(d[3]); n_shift = int'(d[2:0]);
            end
            if (w13) n_freq = (n_freq / 256) * 256 + int'(d);
            if (w14) n_freq = int'(d[2:0]) * 256 + (n_freq % 256);
`ifdef CH1_SWEEP_NEG_QUIRK_EN
            if (w10 && d[3] == 1'b0 && m_neg_used != 0) n_off = 1;
`endif
            if (w14 && d[7]) begin
                n_shadow = n_freq;
                n_timer = (m_period == 0) ? 8 : m_period;
                n_en = (m_period != 0 || m_shift != 0) ? 1 : 0;
                n_off = 0;
                n_neg_used = 0;
                n_step = (m_shift != 0) ? 1 : 0;
            end else if (m_step == 0) begin
                if (sweep_tick) begin
                    if (m_timer <= 1) begin
                        n_timer = (m_period == 0) ? 8 : m_period;
                        if (m_en != 0 && m_period != 0 && m_off == 0) n_step = 3;
                    end else begin
                        n_timer = m_timer - 1;
                    end
                end
            end else if (m_step == 3) begin
                v = sweep_of(m_shadow, m_shift, m_negate);
                if (m_negate != 0) n_neg_used = 1;
                if (v > 2047) begin
                    n_off = 1; n_step = 0;
                end else begin
                    n_new = v; n_step = (m_shift != 0) ? 2 : 0;
                end
            end else if (m_step == 2) begin
                n_shadow = m_new;
                lo = w13 ? int'(d) : (m_new % 256);
                hi = w14 ? int'(d[2:0]) : (m_new / 256);
                n_freq = hi * 256 + lo;
                n_step = 1;
            end else begin
                if (sweep_of(m_shadow, m_shift, m_negate) > 2047) n_off = 1;
                n_step = 0;
            end
        end
        m_period = n_period; m_negate = n_negate; m_shift = n_shift; m_freq = n_freq;
        m_shadow = n_shadow; m_timer = n_timer; m_en = n_en; m_off = n_off;
        m_neg_used = n_neg_used; m_step = n_step; m_new = n_new;
    endtask

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic pin(string name, logic [31:0] act, logic [31:0] mdl, logic [31:0] exp);
        cmp(name, act, exp);
        cmp({name, "_model"}, mdl, exp);
    endtask

    // Every-cycle comparison against the model, sampled 1 ns after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            cmp("freq", 32'(freq), m_freq);
            cmp("nr10_q", 32'(nr10_q), 128 + m_period * 16 + m_negate * 8 + m_shift);
            cmp("ch1_off", 32'(ch1_off), m_off);
            cmp("busy", 32'(busy), (m_step != 0) ? 1 : 0);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int sel, logic [7:0] v, logic tick);
        apu_wr = 1'b1; ff10 = (sel == 10); ff13 = (sel == 13); ff14 = (sel == 14);
        d = v; sweep_tick = tick;
        @(negedge clk);
        apu_wr = 1'b0; ff10 = 1'b0; ff13 = 1'b0; ff14 = 1'b0; d = 8'd0; sweep_tick = 1'b0;
    endtask

    task automatic pulse_tick();
        sweep_tick = 1'b1;
        @(negedge clk);
        sweep_tick = 1'b0;
    endtask

    initial begin
        int r, s;
        cyc(2);
        pin("rst_nr10", 32'(nr10_q), 128 + m_period * 16 + m_negate * 8 + m_shift, 32'h80);
        pin("rst_freq", 32'(freq), m_freq, 32'd0);
        pin("rst_off", 32'(ch1_off), m_off, 32'd0);
        pin("rst_busy", 32'(busy), (m_step != 0) ? 1 : 0, 32'd0);
        reset = 1'b0;
        cyc(1);

        // Up-sweep: 1024 -> 1536, then the re-check sees 2304 and disables the channel.
        wr(10, 8'h11, 1'b0); wr(13, 8'h00, 1'b0); wr(14, 8'h84, 1'b0);
        pin("trig_busy", 32'(busy), (m_step != 0) ? 1 : 0, 32'd1);
        cyc(3);
        pulse_tick();
        cyc(1);
        pin("up_freq_n1", 32'(freq), m_freq, 32'd1024);
        cyc(1);
        pin("up_freq_n2", 32'(freq), m_freq, 32'd1536);
        pin("up_off_n2", 32'(ch1_off), m_off, 32'd0);
        cyc(1);
        pin("up_off_n3", 32'(ch1_off), m_off, 32'd1);

        // Down-sweep: 1024 -> 512 -> 256 -> 128.
        wr(10, 8'h19, 1'b0); wr(13, 8'h00, 1'b0); wr(14, 8'h84, 1'b0);
        cyc(3);
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            cyc(4);
            pin("dn_freq", 32'(freq), m_freq, 32'd512 >> k);
            pin("dn_off", 32'(ch1_off), m_off, 32'd0);
        end

        // Period 2 from 0x700: no update on the first tick, overflow and freq held after.
        wr(10, 8'h21, 1'b0); wr(13, 8'h00, 1'b0); wr(14, 8'h87, 1'b0);
        cyc(3);
        pulse_tick();
        cyc(4);
        pin("ovf_freq_t1", 32'(freq), m_freq, 32'h700);
        pulse_tick();
        cyc(4);
        pin("ovf_freq_t2", 32'(freq), m_freq, 32'h700);
        pin("ovf_off_t2", 32'(ch1_off), m_off, 32'd1);

        // Trigger and tick in the same clock: tick dropped, timer reloaded.
        wr(10, 8'h19, 1'b0); wr(13, 8'h00, 1'b0); wr(14, 8'h84, 1'b0);
        cyc(3);
        wr(14, 8'h84, 1'b1);
        pin("tt_busy", 32'(busy), (m_step != 0) ? 1 : 0, 32'd1);
        cyc(4);
        pin("tt_freq", 32'(freq), m_freq, 32'd1024);
        pin("tt_busy_idle", 32'(busy), (m_step != 0) ? 1 : 0, 32'd0);
        pulse_tick();
        cyc(4);
        pin("tt_freq_next", 32'(freq), m_freq, 32'd512);

        // Clearing negate after a negate calculation.
        wr(10, 8'h19, 1'b0); wr(13, 8'h00, 1'b0); wr(14, 8'h84, 1'b0);
        cyc(3);
        pulse_tick();
        cyc(4);
        wr(10, 8'h11, 1'b0);
        cyc(1);
`ifdef CH1_SWEEP_NEG_QUIRK_EN
        pin("quirk_off", 32'(ch1_off), m_off, 32'd1);
`else
        pin("quirk_off", 32'(ch1_off), m_off, 32'd0);
`endif

        // Randomized traffic, including selects without the write qualifier and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 19);
            s = $urandom_range(0, 2);
            reset = ($urandom_range(0, 399) == 0);
            apu_wr = (r < 2);
            ff10 = (r < 3) && (s == 0);
            ff13 = (r < 3) && (s == 1);
            ff14 = (r < 3) && (s == 2);
            d = 8'($urandom_range(0, 255));
            sweep_tick = ($urandom_range(0, 4) == 0);
            @(negedge clk);
        end
        reset = 1'b0; apu_wr = 1'b0; ff10 = 1'b0; ff13 = 1'b0; ff14 = 1'b0; d = 8'd0; sweep_tick = 1'b0;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ch1_sweep.md
CH1_SWEEP -- requirements
Module: ch1_sweep

Interface
REQ-001 The block SHALL have port clk, input, 1, system clock; every register updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-003 The block SHALL have port apu_wr, input, 1, CPU write qualifier for APU registers.
REQ-004 The block SHALL have ports ff10, ff13 and ff14, input, 1 each, decoded register selects for NR10, NR13 and NR14.
REQ-005 The block SHALL have port d, input, 8, CPU write data.
REQ-006 The block SHALL have port sweep_tick, input, 1, one-clk pulse at 128 Hz from the frame sequencer.
REQ-007 The block SHALL have port freq, output, 11, current channel-1 frequency.
REQ-008 The block SHALL have port nr10_q, output, 8, NR10 readback, {1, period[2:0], negate, shift[2:0]}.
REQ-009 The block SHALL have port ch1_off, output, 1, level output, 1 = channel disabled by sweep overflow.
REQ-010 The block SHALL have port busy, output, 1, high while the FSM is not in IDLE.

Function
REQ-011 A write SHALL occur when apu_wr=1 and a select is 1 in the same clk: ff10 loads period=d[6:4], negate=d[3], shift=d[2:0]; ff13 loads freq[7:0]=d; ff14 loads freq[10:8]=d[2:0].
REQ-012 A trigger SHALL be a write to ff14 with d[7]=1: shadow<=new freq, timer<=period (period 0 loads 8), en<=(period!=0 || shift!=0), ch1_off<=0, neg_used<=0.
REQ-013 On a trigger with shift!=0, the FSM SHALL enter CHECK the next clk.
REQ-014 The FSM SHALL have states IDLE, CALC, WRITE and CHECK.
REQ-015 In IDLE, sweep_tick SHALL decrement timer; at 1→0 it SHALL reload timer (period 0 reloads 8), and if en=1 and period!=0 the FSM SHALL go to CALC.
REQ-016 CALC SHALL compute new = shadow ± (shadow>>shift) in 12 bits (− when negate=1) and set neg_used=1 if negate=1; if new>2047, ch1_off<=1 and the FSM returns to IDLE; else if shift!=0 it goes to WRITE, otherwise to IDLE.
REQ-017 WRITE SHALL set shadow<=new[10:0] and freq<=new[10:0], then go to CHECK.
REQ-018 CHECK SHALL recompute from shadow without storing it, set ch1_off<=1 if the result is >2047, and go to IDLE.
REQ-019 Latency SHALL be: tick in clk N → freq updated at the edge ending N+2 → overflow flag valid by N+3.
REQ-020 If a trigger and sweep_tick occur in the same clk, the trigger SHALL win, the tick SHALL be dropped and the FSM SHALL restart per REQ-012.
REQ-021 A trigger during CALC, WRITE or CHECK SHALL abort the in-flight update, which SHALL not write freq.
REQ-022 If a CPU ff13/ff14 write and WRITE occur in the same clk, the CPU data SHALL win for the written bits, and the shadow SHALL still update.
REQ-023 A negate-mode subtraction SHALL never underflow; the 12-bit result of a subtraction SHALL be ≤ shadow.
REQ-024 ch1_off SHALL stay at 1 until the next trigger or reset.
REQ-025 A sweep_tick while ch1_off=1 SHALL still run the timer and SHALL NOT change freq.

Reset
REQ-026 reset=1 SHALL set period, negate, shift, freq, shadow, timer, en, neg_used and ch1_off to 0, the FSM to IDLE and busy to 0, so nr10_q reads 8'h80.
REQ-027 Reset SHALL take priority over any write, trigger or tick in the same clk, and SHALL abort an in-flight update.

Configuration
REQ-028 With CH1_SWEEP_NEG_QUIRK_EN defined, an NR10 write that clears negate while neg_used=1 SHALL set ch1_off=1 on the next clk.
REQ-029 Without CH1_SWEEP_NEG_QUIRK_EN, that write SHALL only update the register; neg_used logic may be omitted.

Verification
REQ-030 The bench SHALL reset then read nr10_q → 8'h80, freq=0, ch1_off=0, busy=0.
REQ-031 The bench SHALL write NR10=8'h11, NR13=8'h00, NR14=8'h84 (freq 1024), then pulse sweep_tick once → freq=1536 two clks later, then the CHECK result 2304 → ch1_off=1.
REQ-032 The bench SHALL write NR10=8'h19 with freq 1024, trigger, then pulse 3 ticks → freq 512, 256, 128, with ch1_off=0.
REQ-033 The bench SHALL write NR10=8'h21, trigger with freq 0x700, then pulse ticks → the first tick has no update, the second tick gives overflow 0x700+0x380>2047 → ch1_off=1 and freq stays 0x700.
REQ-034 The bench SHALL drive a trigger (NR14=8'h84) in the same clk as sweep_tick → no freq update, timer reloaded, busy follows REQ-013.
REQ-035 With the macro defined, the bench SHALL write NR10=8'h19, trigger, pulse 1 tick, then write NR10=8'h11 → ch1_off=1; with the macro undefined, the same sequence → ch1_off=0.
